// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: command bytes, legacy scan codes, host-TX state encoding.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package ps2_pkg;

   // Host-to-device command bytes and the device's acknowledge reply
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] ACK          = 8'hFA;

   // Scan codes already consumed by the keyboard receiver (arrow keys)
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_LEFT  = 8'h6b;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   // Host transmit sequencer states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_DATA      = 3'd3,
      ST_PARITY    = 3'd4,
      ST_STOP      = 3'd5,
      ST_ACK       = 3'd6,
      ST_WAIT_IDLE = 3'd7
   } ps2_tx_state_t;

   // PS/2 frames carry odd parity: the parity bit makes the 9-bit count of ones odd
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioner: 2-flop synchronizer followed by a run-length glitch filter.
// Latency: 2 sync cycles + FILTER_LEN matching samples before filt_out follows the pin.
// Backpressure: none; free-running sampler, one instance per PS/2 line.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_in,
   output logic filt_out
);

   localparam int              CW       = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          filt_q,  filt_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   // Count consecutive samples that disagree with the filtered level; flip once the run is long enough
   always_comb begin
      sync1_d = pin_in;
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State register; an idle PS/2 line is high, so everything resets to 1
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign filt_out = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 11 device-clocked bits, ack check.
// Latency: INHIBIT_CYCLES of clock hold, then paced by the device clock; done/error pulse at the end.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is dropped, never queued.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_drive_low,
   output logic       ps2d_drive_low,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int            IW       = $clog2(INHIBIT_CYCLES + 1);
   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   ps2_tx_state_t state_q, state_d;
   logic [IW-1:0] inh_q,   inh_d;     // inhibit hold counter
   logic [TW-1:0] tmo_q,   tmo_d;     // clock-release-to-ack watchdog
   logic [8:0]    sh_q,    sh_d;      // {parity, data} frame payload
   logic [3:0]    bit_q,   bit_d;     // next payload bit to drive
   logic          c_low_q, c_low_d;
   logic          d_low_q, d_low_d;
   logic          nack_q,  nack_d;    // data level seen at the 11th falling edge
   logic          done_q,  done_d;
   logic          err_q,   err_d;
   logic          fc_prev_q, fc_prev_d;

   logic fc, fd, fall;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
      .clk      (clk),
      .reset    (reset),
      .pin_in   (ps2c_in),
      .filt_out (fc)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
      .clk      (clk),
      .reset    (reset),
      .pin_in   (ps2d_in),
      .filt_out (fd)
   );

   // Device clock falling edge, taken on the filtered level so glitches never shift a bit
   assign fall = fc_prev_q & ~fc;

   // Sequencer: next state, line drives and status pulses; watchdog overrides everything after INHIBIT
   always_comb begin
      state_d   = state_q;
      inh_d     = inh_q;
      tmo_d     = '0;
      sh_d      = sh_q;
      bit_d     = bit_q;
      c_low_d   = 1'b0;
      d_low_d   = d_low_q;
      nack_d    = nack_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      fc_prev_d = fc;

      case (state_q)
         ST_IDLE: begin
            d_low_d = 1'b0;
            inh_d   = '0;
            bit_d   = '0;
            if (tx_valid) begin
               sh_d    = {odd_parity(tx_data), tx_data};
               state_d = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inh_q == INH_LAST) begin
               inh_d   = '0;
               d_low_d = 1'b1;            // start bit, held while clock is released
               state_d = ST_REQ;
            end else begin
               inh_d = inh_q + IW'(1);
            end
         end
         ST_REQ: begin
            if (fall) begin
               d_low_d = ~sh_q[0];
               bit_d   = 4'd1;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            // bit index 8 is the parity bit, so the last data edge hands over to PARITY
            if (fall) begin
               d_low_d = ~sh_q[bit_q];
               if (bit_q == 4'd8) begin
                  state_d = ST_PARITY;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (fall) begin
               d_low_d = 1'b0;            // stop bit is a released (high) line
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               nack_d  = fd;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (nack_q) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            d_low_d = 1'b0;
            if (fc && fd) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            d_low_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      if (state_q != ST_IDLE && state_q != ST_INHIBIT) begin
         tmo_d = tmo_q + TW'(1);
         if (tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            d_low_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
         end
      end

      // Inhibit pulls clock for the whole hold and data only on its final cycle
      if (state_d == ST_INHIBIT) begin
         c_low_d = 1'b1;
         d_low_d = (inh_d == INH_LAST);
      end
   end

   // State and registered-output flops; line drives are registered so the pins never glitch
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         inh_q     <= '0;
         tmo_q     <= '0;
         sh_q      <= '0;
         bit_q     <= '0;
         c_low_q   <= 1'b0;
         d_low_q   <= 1'b0;
         nack_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         fc_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         inh_q     <= inh_d;
         tmo_q     <= tmo_d;
         sh_q      <= sh_d;
         bit_q     <= bit_d;
         c_low_q   <= c_low_d;
         d_low_q   <= d_low_d;
         nack_q    <= nack_d;
         done_q    <= done_d;
         err_q     <= err_d;
         fc_prev_q <= fc_prev_d;
      end
   end

   assign tx_ready       = (state_q == ST_IDLE);
   assign busy           = (state_q != ST_IDLE);
   assign ps2c_drive_low = c_low_q;
   assign ps2d_drive_low = d_low_q;
   assign tx_done        = done_q;
   assign tx_error       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a behavioural PS/2 device.
// Latency: device half-period HALF clk cycles; one transaction ~1k cycles.
// Backpressure: bench only offers a byte when tx_ready is high, except the deliberate busy pulse.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 20;
   localparam int FLT  = 4;
   localparam int TMO  = 5000;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       ps2c_in, ps2d_in;
   logic       ps2c_drive_low, ps2d_drive_low;
   logic       busy, tx_done, tx_error;
   logic       dev_clk, dev_data;

   int   n_chk = 0;
   int   n_pass = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   logic both_seen = 1'b0;

   always #5 clk = ~clk;

   // Wired-AND bus: either side can pull a line low
   assign ps2c_in = dev_clk  & ~ps2c_drive_low;
   assign ps2d_in = dev_data & ~ps2d_drive_low;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .FILTER_LEN     (FLT),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready),
      .ps2c_in        (ps2c_in),
      .ps2d_in        (ps2d_in),
      .ps2c_drive_low (ps2c_drive_low),
      .ps2d_drive_low (ps2d_drive_low),
      .busy           (busy),
      .tx_done        (tx_done),
      .tx_error       (tx_error)
   );

   // Pulse counters for done/error
   always @(negedge clk) begin
      if (tx_done === 1'b1)  done_cnt++;
      if (tx_error === 1'b1) err_cnt++;
      if (tx_done === 1'b1 && tx_error === 1'b1) both_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Called on the first cycle after acceptance; returns on the first cycle the clock is released
   task automatic measure_inhibit(input string tag);
      int   inh;
      int   dl;
      logic dlast;
      inh = 0; dl = 0; dlast = 1'b0;
      while (ps2c_drive_low === 1'b1 && inh < 1000) begin
         inh++;
         if (ps2d_drive_low === 1'b1) dl++;
         dlast = ps2d_drive_low;
         @(negedge clk);
      end
      check({tag, "_inh_len"},    32'(inh), 32'(INH));
      check({tag, "_inh_dlow"},   32'(dl), 32'd1);
      check({tag, "_inh_dlast"},  32'(dlast), 32'd1);
      check({tag, "_start_bit"},  32'(ps2d_drive_low), 32'd1);
   endtask

   // Device: 11 clock pulses, samples host data on rising edges 1..10, acks (or not) at edge 11.
   // stop_edge < 12 abandons the frame with the clock held low after that falling edge.
   task automatic dev_xfer(input int ack, input int glitch_edge, input int stop_edge,
                           output logic [9:0] bits);
      int n;
      bits = '0;
      n = 0;
      while (!(ps2c_drive_low === 1'b0 && ps2d_drive_low === 1'b1) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      for (int e = 1; e <= 11; e++) begin
         if (e == 11) begin
            if (ack != 0) dev_data = 1'b0;
            repeat (20) @(negedge clk);
         end
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (e == stop_edge) return;
         dev_clk = 1'b1;
         if (e <= 10) bits[e-1] = ps2d_in;
         if (e == 11) dev_data = 1'b1;
         if (e == glitch_edge) begin
            repeat (10) @(negedge clk);
            check("busy_not_ready", 32'(tx_ready), 32'd0);
            dev_clk  = 1'b0;
            tx_valid = 1'b1;
            tx_data  = 8'h55;
            repeat (3) @(negedge clk);
            dev_clk  = 1'b1;
            tx_valid = 1'b0;
            repeat (HALF - 13) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
      end
   endtask

   task automatic full_tx(input logic [7:0] d, input logic [9:0] exp_bits, input int ack,
                          input int glitch_edge, input string tag);
      int         d0, e0;
      logic [9:0] bits;
      check({tag, "_ready_before"}, 32'(tx_ready), 32'd1);
      d0 = done_cnt;
      e0 = err_cnt;
      send(d);
      measure_inhibit(tag);
      dev_xfer(ack, glitch_edge, 99, bits);
      check({tag, "_frame_bits"}, 32'(bits), 32'(exp_bits));
      repeat (200) @(negedge clk);
      check({tag, "_done_pulses"},  32'(done_cnt - d0), (ack != 0) ? 32'd1 : 32'd0);
      check({tag, "_err_pulses"},   32'(err_cnt - e0),  (ack != 0) ? 32'd0 : 32'd1);
      check({tag, "_ready_after"},  32'(tx_ready), 32'd1);
      check({tag, "_busy_after"},   32'(busy), 32'd0);
      check({tag, "_clk_released"}, 32'(ps2c_drive_low), 32'd0);
      check({tag, "_dat_released"}, 32'(ps2d_drive_low), 32'd0);
   endtask

   initial begin
      int         n;
      int         e0, d0;
      logic [9:0] bits;

      dev_clk  = 1'b1;
      dev_data = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      reset    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_clow",  32'(ps2c_drive_low), 32'd0);
      check("rst_dlow",  32'(ps2d_drive_low), 32'd0);
      check("rst_done",  32'(tx_done), 32'd0);
      check("rst_err",   32'(tx_error), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Frames are {stop, parity, data}: ED -> bits 1,0,1,1,0,1,1,1 then parity 1, stop 1
      full_tx(CMD_SET_LEDS, 10'b11_1110_1101, 1, 0, "ed");
      full_tx(8'h00,        10'b11_0000_0000, 1, 0, "x00");
      full_tx(8'h01,        10'b10_0000_0001, 1, 0, "x01");

      // Device leaves data high at edge 11: F4 has five ones, parity 0
      full_tx(CMD_ENABLE,   10'b10_1111_0100, 0, 0, "nack");

      // Clock glitch and a dropped busy-time request during DATA: 3C has four ones, parity 1
      full_tx(8'h3C,        10'b11_0011_1100, 1, 3, "glitch");

      // Silent device: watchdog fires TMO cycles after the clock is released
      check("tmo_ready_before", 32'(tx_ready), 32'd1);
      e0 = err_cnt;
      d0 = done_cnt;
      send(SC_UP);
      measure_inhibit("tmo");
      n = 0;
      while (tx_error !== 1'b1 && n < TMO + 1000) begin
         @(negedge clk);
         n++;
      end
      check("tmo_cycles",   32'(n), 32'(TMO));
      check("tmo_busy",     32'(busy), 32'd0);
      check("tmo_clow",     32'(ps2c_drive_low), 32'd0);
      check("tmo_dlow",     32'(ps2d_drive_low), 32'd0);
      repeat (5) @(negedge clk);
      check("tmo_err_pulses",  32'(err_cnt - e0), 32'd1);
      check("tmo_done_pulses", 32'(done_cnt - d0), 32'd0);

      // Reset in the middle of the data phase, then a clean FF frame
      send(CMD_RESET);
      measure_inhibit("rst_mid");
      dev_xfer(1, 0, 5, bits);
      check("rst_mid_bits_so_far", 32'(bits[3:0]), 32'hF);
      check("rst_mid_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_clow",  32'(ps2c_drive_low), 32'd0);
      check("rst_mid_dlow",  32'(ps2d_drive_low), 32'd0);
      check("rst_mid_ready", 32'(tx_ready), 32'd1);
      check("rst_mid_busy",  32'(busy), 32'd0);
      reset    = 1'b0;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (20) @(negedge clk);
      full_tx(CMD_RESET, 10'b11_1111_1111, 1, 0, "ff");

      check("done_err_exclusive", 32'(both_seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
